// File: rtl/regfile_arb_pkg.sv
// Shared types and constants for the register-file read-port arbiter.
package regfile_arb_pkg;

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} arb_state_e;

  localparam int ADDR_W = 5;
  localparam int DATA_W = 64;
  localparam logic [4:0] XZR_IDX = 5'd31;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first asserted request at or after ptr, ascending with wrap.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int PW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [PW-1:0] gnt_idx,
  output logic          any
);

  logic [PW-1:0] idx;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    any     = 1'b0;
    idx     = '0;
    for (int i = 0; i < N; i++) begin
      idx = PW'((int'(ptr) + i) % N);
      if (!any && req[idx]) begin
        any          = 1'b1;
        gnt[idx]     = 1'b1;
        gnt_idx      = idx;
      end
    end
  end

endmodule

// File: rtl/regfile_read_arbiter.sv
// Round-robin sharing of the single register-file read port among NUM_REQ requesters.
// Build option XZR_EN: index 31 is the zero register and bypasses the read port.
module regfile_read_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = regfile_arb_pkg::DATA_W,
  parameter int ADDR_W  = regfile_arb_pkg::ADDR_W
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic [NUM_REQ-1:0]              req_valid,
  input  logic [NUM_REQ-1:0][ADDR_W-1:0]  req_addr,
  output logic [NUM_REQ-1:0]              req_ready,
  output logic [ADDR_W-1:0]               rd_addr,
  input  logic [DATA_W-1:0]               rd_data,
  output logic [NUM_REQ-1:0]              rsp_valid,
  output logic [DATA_W-1:0]               rsp_data,
  input  logic [NUM_REQ-1:0]              rsp_ready,
  output logic                            busy
);
  import regfile_arb_pkg::*;

  localparam int PW = $clog2(NUM_REQ);

  arb_state_e        state_q, state_d;
  logic [PW-1:0]     owner_q, owner_d;
  logic [PW-1:0]     ptr_q, ptr_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;

  logic [NUM_REQ-1:0] gnt;
  logic [PW-1:0]      gnt_idx;
  logic               gnt_any;
  logic               accept;

  rr_arbiter #(.N(NUM_REQ), .PW(PW)) u_rr (
    .req     (req_valid),
    .ptr     (ptr_q),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .any     (gnt_any)
  );

  // Grants are offered only while idle and out of reset.
  assign req_ready = (state_q == IDLE && reset_n) ? gnt : '0;
  assign accept    = gnt_any && |(req_valid & req_ready);

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    ptr_d      = ptr_q;
    rd_addr_d  = rd_addr_q;
    rsp_data_d = rsp_data_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          owner_d = gnt_idx;
          ptr_d   = (gnt_idx == PW'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
`ifdef XZR_EN
          if (req_addr[gnt_idx] == ADDR_W'(XZR_IDX)) begin
            rsp_data_d = '0;
            state_d    = RESP;
          end else begin
            rd_addr_d = req_addr[gnt_idx];
            state_d   = ISSUE;
          end
`else
          rd_addr_d = req_addr[gnt_idx];
          state_d   = ISSUE;
`endif
        end
      end
      ISSUE: begin
        rsp_data_d = rd_data;
        state_d    = RESP;
      end
      RESP: begin
        if (rsp_ready[owner_q]) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      owner_q    <= '0;
      ptr_q      <= '0;
      rd_addr_q  <= '0;
      rsp_data_q <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      ptr_q      <= ptr_d;
      rd_addr_q  <= rd_addr_d;
      rsp_data_q <= rsp_data_d;
    end
  end

  always_comb begin
    rsp_valid = '0;
    if (state_q == RESP) rsp_valid[owner_q] = 1'b1;
  end

  assign rd_addr  = rd_addr_q;
  assign rsp_data = rsp_data_q;
  assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_regfile_read_arbiter.sv
// Self-checking bench for regfile_read_arbiter; honours XZR_EN when defined.
module tb_regfile_read_arbiter;
  localparam int N = 4;

  logic                 clk = 1'b0;
  logic                 reset_n;
  logic [N-1:0]         req_valid;
  logic [N-1:0][4:0]    req_addr;
  logic [N-1:0]         req_ready;
  logic [4:0]           rd_addr;
  logic [63:0]          rd_data;
  logic [N-1:0]         rsp_valid;
  logic [63:0]          rsp_data;
  logic [N-1:0]         rsp_ready;
  logic                 busy;

  logic [63:0] regs [32];
  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;
  int m_ptr = 0;
  logic [4:0] m_rd_addr = '0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  assign rd_data = regs[rd_addr];

  regfile_read_arbiter #(.NUM_REQ(N), .DATA_W(64), .ADDR_W(5)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .req_valid (req_valid),
    .req_addr  (req_addr),
    .req_ready (req_ready),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .rsp_ready (rsp_ready),
    .busy      (busy)
  );

  function automatic logic [63:0] exp_val(input logic [4:0] a);
`ifdef XZR_EN
    if (a == 5'd31) return 64'd0;
`endif
    return 64'h1111_0000_0000_0000 + 64'(a);
  endfunction

  function automatic int rr_pick(input logic [N-1:0] v, input int p);
    for (int k = 0; k < N; k++)
      if (v[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  // One full transaction from an idle cycle; checks handshake, issue and response phases.
  task automatic run_txn(input logic [N-1:0] v, input logic [N-1:0][4:0] a, input int stall,
                         output int w);
    logic [N-1:0] exp_rdy, oh;
    logic [4:0]   exp_rd;
    logic [63:0]  exp_d;
    int           lat, gc;
    req_valid = v; req_addr = a; rsp_ready = '0;
    #1;
    gc = cyc;
    w = rr_pick(v, m_ptr);
    exp_rdy = (w < 0) ? '0 : (N'(1) << w);
    n_vec++; if (req_ready !== exp_rdy) begin n_err++; $display("FAIL idle_req_ready: got %b want %b", req_ready, exp_rdy); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL idle_busy: got %b want 0", busy); end
    if (w < 0) begin
      $display("txn @%0d: valid=%b no grant", gc, v);
      @(posedge clk); #1;
      return;
    end
    oh    = exp_rdy;
    exp_d = exp_val(a[w]);
    lat   = 2;
`ifdef XZR_EN
    if (a[w] == 5'd31) lat = 1;
`endif
    if (lat == 2) m_rd_addr = a[w];
    exp_rd = m_rd_addr;
    m_ptr  = (w + 1) % N;
    @(posedge clk); #1;
    req_valid = v & ~oh;
    if (lat == 2) begin
      #1;
      n_vec++; if (rsp_valid !== '0) begin n_err++; $display("FAIL issue_rsp_valid: got %b want 0", rsp_valid); end
      n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL issue_busy: got %b want 1", busy); end
      n_vec++; if (rd_addr !== exp_rd) begin n_err++; $display("FAIL issue_rd_addr: got %0d want %0d", rd_addr, exp_rd); end
      n_vec++; if (req_ready !== '0) begin n_err++; $display("FAIL issue_req_ready: got %b want 0", req_ready); end
      @(posedge clk); #1;
    end
    for (int s = 0; s <= stall; s++) begin
      rsp_ready = (s == stall) ? (oh | (N'($urandom) & ~oh)) : ~oh;
      #1;
      n_vec++; if (rsp_valid !== oh) begin n_err++; $display("FAIL resp_valid: got %b want %b", rsp_valid, oh); end
      n_vec++; if (rsp_data !== exp_d) begin n_err++; $display("FAIL resp_data: got %h want %h", rsp_data, exp_d); end
      n_vec++; if (rd_addr !== exp_rd) begin n_err++; $display("FAIL resp_rd_addr: got %0d want %0d", rd_addr, exp_rd); end
      n_vec++; if (req_ready !== '0) begin n_err++; $display("FAIL resp_req_ready: got %b want 0", req_ready); end
      @(posedge clk); #1;
    end
    rsp_ready = '0;
    n_vec++; if (busy !== 1'b0 || rsp_valid !== '0) begin n_err++; $display("FAIL post_resp_idle: busy=%b rsp_valid=%b want 0/0", busy, rsp_valid); end
    $display("txn @%0d: valid=%b grant=%0d addr=%0d stall=%0d data=%h", gc, v, w, a[w], stall, exp_d);
  endtask

  task automatic test_reset;
    logic [N-1:0][4:0] a;
    int w;
    reset_n = 1'b0; req_valid = 4'hF; req_addr = '0; rsp_ready = '0;
    repeat (2) @(posedge clk); #1;
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_busy: got %b want 0", busy); end
    n_vec++; if (rsp_valid !== '0) begin n_err++; $display("FAIL rst_rsp_valid: got %b want 0", rsp_valid); end
    n_vec++; if (rd_addr !== '0) begin n_err++; $display("FAIL rst_rd_addr: got %0d want 0", rd_addr); end
    n_vec++; if (rsp_data !== '0) begin n_err++; $display("FAIL rst_rsp_data: got %h want 0", rsp_data); end
    n_vec++; if (req_ready !== '0) begin n_err++; $display("FAIL rst_req_ready: got %b want 0", req_ready); end
    reset_n = 1'b1; req_valid = '0; m_ptr = 0; m_rd_addr = '0;
    @(posedge clk); #1;
    req_valid = 4'b0100; req_addr[2] = 5'd9;
    #1;
    n_vec++; if (req_ready !== 4'b0100) begin n_err++; $display("FAIL rst_pre_grant: got %b want 0100", req_ready); end
    @(posedge clk); #1; req_valid = '0;
    @(posedge clk); #2;
    n_vec++; if (rsp_valid !== 4'b0100) begin n_err++; $display("FAIL rst_pre_resp: got %b want 0100", rsp_valid); end
    #2 reset_n = 1'b0;
    #1;
    n_vec++; if (rsp_valid !== '0 || busy !== 1'b0) begin n_err++; $display("FAIL rst_async: rsp_valid=%b busy=%b want 0/0", rsp_valid, busy); end
    n_vec++; if (rd_addr !== '0) begin n_err++; $display("FAIL rst_async_rd_addr: got %0d want 0", rd_addr); end
    @(posedge clk); #1;
    reset_n = 1'b1; m_ptr = 0; m_rd_addr = '0;
    a = {5'd4, 5'd3, 5'd2, 5'd1};
    run_txn(4'hF, a, 0, w);
  endtask

  task automatic test_fairness;
    logic [N-1:0][4:0] fa;
    logic [N-1:0] exp_rdy, exp_rv;
    int order [5];
    order = '{0, 1, 2, 3, 0};
    fa = {5'd12, 5'd9, 5'd5, 5'd3};
    reset_n = 1'b0; req_valid = '0; rsp_ready = '0; req_addr = fa;
    @(posedge clk); #1;
    reset_n = 1'b1;
    for (int k = 0; k < 15; k++) begin
      req_valid = (k < 13) ? 4'hF : 4'h0;
      rsp_ready = 4'hF;
      #1;
      exp_rdy = (k % 3 == 0) ? (N'(1) << order[k / 3]) : '0;
      exp_rv  = (k % 3 == 2) ? (N'(1) << order[k / 3]) : '0;
      n_vec++; if (req_ready !== exp_rdy) begin n_err++; $display("FAIL fair_req_ready k=%0d: got %b want %b", k, req_ready, exp_rdy); end
      n_vec++; if (rsp_valid !== exp_rv) begin n_err++; $display("FAIL fair_rsp_valid k=%0d: got %b want %b", k, rsp_valid, exp_rv); end
      if (k % 3 == 2) begin
        n_vec++; if (rsp_data !== exp_val(fa[order[k / 3]])) begin n_err++; $display("FAIL fair_rsp_data k=%0d: got %h want %h", k, rsp_data, exp_val(fa[order[k / 3]])); end
        $display("txn fair k=%0d: grant=%0d data=%h", k, order[k / 3], rsp_data);
      end
      @(posedge clk); #1;
    end
    req_valid = '0; rsp_ready = '0;
    m_ptr = 1; m_rd_addr = 5'd3;
  endtask

  task automatic test_backpressure;
    logic [N-1:0][4:0] a;
    int w;
    a = {5'd0, 5'd21, 5'd17, 5'd0};
    run_txn(4'b0110, a, 5, w);
    run_txn(4'b0100, a, 0, w);
  endtask

  task automatic test_wrap;
    logic [N-1:0][4:0] a;
    int w;
    a = {5'd30, 5'd0, 5'd0, 5'd11};
    run_txn(4'b1001, a, 2, w);
    run_txn(4'b1001, a, 2, w);
  endtask

  task automatic test_single;
    logic [N-1:0][4:0] a;
    int w;
    a = '0; a[1] = 5'd7;
    run_txn(4'b0010, a, 0, w);
  endtask

  task automatic test_xzr;
    logic [N-1:0][4:0] a;
    int w;
    a = {5'd31, 5'd31, 5'd31, 5'd31};
    run_txn(4'b0100, a, 1, w);
    run_txn(4'b0001, a, 0, w);
  endtask

  task automatic test_random;
    logic [N-1:0][4:0] a;
    int w;
    for (int t = 0; t < 40; t++) begin
      for (int i = 0; i < N; i++)
        a[i] = ($urandom_range(0, 3) == 0) ? 5'd31 : 5'($urandom);
      run_txn(N'($urandom), a, $urandom_range(0, 3), w);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 32; i++) regs[i] = 64'h1111_0000_0000_0000 + 64'(i);
    test_reset();
    test_fairness();
    test_backpressure();
    test_wrap();
    test_single();
    test_xzr();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
